serial_add_sched: RTL



---
 rtl/serial_add_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial adder (two half adders plus a
// carry flop) between two requesters; the sum is returned over valid/ready.
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant_vld;
    logic             grant;
    logic [1:0]       ha0;
    logic [1:0]       ha1;
    logic             bit_s;
    logic             bit_c;

    // Returns {carry, sum} of a single half adder.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    always_comb begin
        ha0   = half_add(a_q[0], b_q[0]);
        ha1   = half_add(ha0[0], carry_q);
        bit_s = ha1[0];
        bit_c = ha0[1] | ha1[1];
    end

    // Under contention the requester that did not win last time is granted.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state_q == IDLE) && grant_vld && !grant;
    assign req1_ready = (state_q == IDLE) && grant_vld && grant;
    assign res_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign res_sum    = sum_q;
    assign res_cout   = cout_q;
    assign res_id     = id_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        id_d    = id_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    a_d     = grant ? req1_a : req0_a;
                    b_d     = grant ? req1_b : req0_b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    id_d    = grant;
                    last_d  = grant;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so bit 0 lands in place after WIDTH steps.
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {bit_s, sum_q[WIDTH-1:1]};
                carry_d = bit_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = bit_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
